// File: rtl/alu_sequencer_pkg.sv
// Shared types for the execute-stage alu sequencer: opcodes, operands,
// exception codes, sequencer states and the divide-class opcode test.
package alu_sequencer_pkg;

  typedef logic [63:0] quad_t;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    ADC  = 4'd1,
    SUB  = 4'd2,
    SBC  = 4'd3,
    AND  = 4'd4,
    OR   = 4'd5,
    XOR  = 4'd6,
    SHL  = 4'd7,
    SHR  = 4'd8,
    MUL  = 4'd9,
    DIV  = 4'd10,
    ADIV = 4'd11,
    MOD  = 4'd12,
    AMOD = 4'd13
  } opcode_t;

  typedef enum logic [1:0] {
    NONE           = 2'd0,
    DIVIDE_BY_ZERO = 2'd1
  } exception_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    TRAP = 2'd3
  } seq_state_t;

  // Hold counter width; covers DIV_CYCLES up to 16 (counter loads DIV_CYCLES-1).
  localparam int CNT_W = 4;

  function automatic logic is_div_op(input opcode_t op);
    return (op == DIV) || (op == ADIV) || (op == MOD) || (op == AMOD);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundles the op-in, alu, writeback, flag and trap signals of the sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface alu_sequencer_if #(
  parameter int REG_ADDR_W = 5
) ();

  logic                              in_valid;
  logic                              in_ready;
  alu_sequencer_pkg::opcode_t        in_op;
  alu_sequencer_pkg::quad_t          in_a;
  alu_sequencer_pkg::quad_t          in_b;
  logic [REG_ADDR_W-1:0]             in_rd;

  alu_sequencer_pkg::opcode_t        alu_op;
  logic                              alu_carry;
  alu_sequencer_pkg::quad_t          alu_a;
  alu_sequencer_pkg::quad_t          alu_b;
  alu_sequencer_pkg::quad_t          alu_result;
  logic                              alu_c;
  logic                              alu_z;
  logic                              alu_n;
  alu_sequencer_pkg::exception_t     alu_exc;

  logic                              wb_valid;
  logic                              wb_ready;
  logic [REG_ADDR_W-1:0]             wb_rd;
  alu_sequencer_pkg::quad_t          wb_data;

  logic                              flag_c;
  logic                              flag_z;
  logic                              flag_n;

  logic                              trap_valid;
  alu_sequencer_pkg::exception_t     trap_cause;
  logic                              trap_ack;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_rd,
    output in_ready,
    output alu_op, alu_carry, alu_a, alu_b,
    input  alu_result, alu_c, alu_z, alu_n, alu_exc,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output flag_c, flag_z, flag_n,
    output trap_valid, trap_cause,
    input  trap_ack
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_rd,
    input  in_ready,
    input  alu_op, alu_carry, alu_a, alu_b,
    output alu_result, alu_c, alu_z, alu_n, alu_exc,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  flag_c, flag_z, flag_n,
    input  trap_valid, trap_cause,
    output trap_ack
  );

endinterface

// File: rtl/alu_sequencer.sv
// Execute-stage controller: holds an accepted op on the sibling alu's ports,
// then hands the result to writeback (updating C/Z/N) or raises a trap.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_sequencer_if.slave bus
);

  seq_state_t            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  opcode_t               op_q,      op_d;
  quad_t                 a_q,       a_d;
  quad_t                 b_q,       b_d;
  logic                  carry_q,   carry_d;
  logic [REG_ADDR_W-1:0] rd_q,      rd_d;
  quad_t                 wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,   wb_rd_d;
  logic                  flag_c_q,  flag_c_d;
  logic                  flag_z_q,  flag_z_d;
  logic                  flag_n_q,  flag_n_d;
  exception_t            cause_q,   cause_d;

  logic                  in_ready_c;
  logic                  accept;

  localparam logic [CNT_W-1:0] DIV_HOLD = CNT_W'(DIV_CYCLES - 1);

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    cause_d    = cause_q;
    in_ready_c = 1'b0;
    accept     = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.alu_exc != NONE) begin
          cause_d = bus.alu_exc;
          state_d = TRAP;
        end else begin
          wb_data_d = bus.alu_result;
          wb_rd_d   = rd_q;
          flag_c_d  = bus.alu_c;
          flag_z_d  = bus.alu_z;
          flag_n_d  = bus.alu_n;
          state_d   = WB;
        end
      end

      WB: begin
        // Accepting while the writeback drains keeps back-to-back ops at 2 cycles.
        in_ready_c = bus.wb_ready;
        if (bus.wb_ready) begin
          if (bus.in_valid) begin
            accept  = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end

      TRAP: begin
        if (bus.trap_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // The carry operand is the flag as it stands now: the previous op's
    // flags were committed on its EXEC exit edge, before this acceptance.
    if (accept) begin
      op_d    = bus.in_op;
      a_d     = bus.in_a;
      b_d     = bus.in_b;
      rd_d    = bus.in_rd;
      carry_d = flag_c_q;
      cnt_d   = is_div_op(bus.in_op) ? DIV_HOLD : '0;
    end
  end

  // NOTE: operand and result registers are reset too, because their values
  // are visible on the alu and writeback ports while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= opcode_t'('0);
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      cause_q   <= NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
      cause_q   <= cause_d;
    end
  end

  // The reset state is IDLE, so ready is masked to stay low while in reset.
  assign bus.in_ready   = in_ready_c & rst_n;

  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_carry  = carry_q;

  assign bus.wb_valid   = (state_q == WB);
  assign bus.wb_data    = wb_data_q;
  assign bus.wb_rd      = wb_rd_q;

  assign bus.flag_c     = flag_c_q;
  assign bus.flag_z     = flag_z_q;
  assign bus.flag_n     = flag_n_q;

  assign bus.trap_valid = (state_q == TRAP);
  assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: stub alu, timeline-based reference model checked every
// cycle, directed literal scenarios, randomized traffic and a mid-op reset.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int DIV_CYCLES = 4;
  localparam int RW         = 5;

  typedef struct packed {
    quad_t      r;
    logic       c;
    logic       z;
    logic       n;
    exception_t e;
  } alu_out_t;

  typedef struct {
    opcode_t    op;
    quad_t      a;
    quad_t      b;
    logic       ci;
    logic [RW-1:0] rd;
    alu_out_t   o;
    int         done;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_sequencer_if #(.REG_ADDR_W(RW)) bus ();

  alu_sequencer #(.DIV_CYCLES(DIV_CYCLES), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic alu_out_t ref_alu(input opcode_t op, input quad_t a, input quad_t b,
                                       input logic ci);
    alu_out_t    o;
    logic [64:0] w;
    o = '0;
    w = '0;
    case (op)
      ADD: w = {1'b0, a} + {1'b0, b};
      ADC: w = {1'b0, a} + {1'b0, b} + 65'(ci);
      SUB: w = {1'b0, a} - {1'b0, b};
      SBC: w = {1'b0, a} - {1'b0, b} - 65'(ci);
      AND: w = {1'b0, a & b};
      OR:  w = {1'b0, a | b};
      XOR: w = {1'b0, a ^ b};
      SHL: w = {1'b0, a} << b[5:0];
      SHR: w = {1'b0, a >> b[5:0]};
      MUL: w = {1'b0, a * b};
      DIV, ADIV, MOD, AMOD: begin
        if (b == '0) o.e = DIVIDE_BY_ZERO;
        else if ((op == ADIV || op == AMOD) && a == 64'h8000_0000_0000_0000 && b == '1)
          w = (op == ADIV) ? {1'b0, a} : '0;
        else if (op == DIV)  w = {1'b0, a / b};
        else if (op == MOD)  w = {1'b0, a % b};
        else if (op == ADIV) w = {1'b0, quad_t'($signed(a) / $signed(b))};
        else                 w = {1'b0, quad_t'($signed(a) % $signed(b))};
      end
      default: w = '0;
    endcase
    o.r = w[63:0];
    o.c = w[64];
    o.z = (o.r == '0);
    o.n = o.r[63];
    return o;
  endfunction

  alu_out_t stub;
  always_comb begin
    stub           = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_carry);
    bus.alu_result = stub.r;
    bus.alu_c      = stub.c;
    bus.alu_z      = stub.z;
    bus.alu_n      = stub.n;
    bus.alu_exc    = stub.e;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  bit            m_pend = 0;
  pend_t         p;
  logic          m_fc, m_fz, m_fn;
  quad_t         m_wbd;
  logic [RW-1:0] m_wbr;
  exception_t    m_cause;
  int            cyc = 0;

  always @(negedge clk) begin : compare
    int phase;  // 0 idle, 1 executing, 2 writeback offered, 3 trap offered
    if (!rst_n) begin
      m_pend = 0; m_fc = 0; m_fz = 0; m_fn = 0;
      m_wbd = '0; m_wbr = '0; m_cause = NONE;
      check("rst_in_ready",   64'(bus.in_ready),   64'd0);
      check("rst_wb_valid",   64'(bus.wb_valid),   64'd0);
      check("rst_trap_valid", 64'(bus.trap_valid), 64'd0);
    end else begin
      if (!m_pend)           phase = 0;
      else if (cyc < p.done) phase = 1;
      else if (p.o.e == NONE) phase = 2;
      else                   phase = 3;

      check("wb_valid",   64'(bus.wb_valid),   64'(phase == 2));
      check("trap_valid", 64'(bus.trap_valid), 64'(phase == 3));
      check("flag_c",     64'(bus.flag_c),     64'(m_fc));
      check("flag_z",     64'(bus.flag_z),     64'(m_fz));
      check("flag_n",     64'(bus.flag_n),     64'(m_fn));
      check("wb_data",    bus.wb_data,         m_wbd);
      check("wb_rd",      64'(bus.wb_rd),      64'(m_wbr));
      check("trap_cause", 64'(bus.trap_cause), 64'(m_cause));
      case (phase)
        0: check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        1: begin
          check("in_ready_exec", 64'(bus.in_ready),  64'd0);
          check("alu_op",        64'(bus.alu_op),    64'(p.op));
          check("alu_a",         bus.alu_a,          p.a);
          check("alu_b",         bus.alu_b,          p.b);
          check("alu_carry",     64'(bus.alu_carry), 64'(p.ci));
        end
        2: check("in_ready_wb",   64'(bus.in_ready), 64'(bus.wb_ready));
        default: check("in_ready_trap", 64'(bus.in_ready), 64'd0);
      endcase

      // What the coming clock edge does to the model.
      if (phase == 1 && cyc + 1 == p.done) begin
        if (p.o.e == NONE) begin
          m_wbd = p.o.r; m_wbr = p.rd;
          m_fc = p.o.c; m_fz = p.o.z; m_fn = p.o.n;
        end else begin
          m_cause = p.o.e;
        end
      end
      if (phase == 3 && bus.trap_ack) m_pend = 0;
      if (phase == 2 && bus.wb_ready) m_pend = 0;
      if ((phase == 0 || (phase == 2 && bus.wb_ready)) && bus.in_valid) begin
        p.op   = bus.in_op;
        p.a    = bus.in_a;
        p.b    = bus.in_b;
        p.rd   = bus.in_rd;
        p.ci   = m_fc;
        p.o    = ref_alu(p.op, p.a, p.b, p.ci);
        p.done = cyc + 1 + (is_div_op(p.op) ? DIV_CYCLES : 1);
        m_pend = 1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input opcode_t op, input quad_t a, input quad_t b,
                      input logic [RW-1:0] rd);
    logic ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    for (int k = 0; k < 64 && !ok; k++) begin
      #1;
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  function automatic quad_t rand_q();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 64'd1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return '1;
      4:       return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = ADD;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_rd    = '0;
    bus.wb_ready = 1'b1;
    bus.trap_ack = 1'b0;
    #1;
    check("reset_alu_op",   64'(bus.alu_op),     64'd0);
    check("reset_alu_a",    bus.alu_a,           64'd0);
    check("reset_cause",    64'(bus.trap_cause), 64'(NONE));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Basic ADD 5+7: writeback two cycles after acceptance.
    send(ADD, 64'd5, 64'd7, 5'd3);
    check("basic_alu_a_c1",    bus.alu_a,         64'd5);
    check("basic_alu_b_c1",    bus.alu_b,         64'd7);
    check("basic_no_wb_c1",    64'(bus.wb_valid), 64'd0);
    step();
    check("basic_wb_valid_c2", 64'(bus.wb_valid), 64'd1);
    check("basic_wb_data",     bus.wb_data,       64'd12);
    check("basic_wb_rd",       64'(bus.wb_rd),    64'd3);
    check("basic_flags",       64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'd0);
    step();

    // Carry chain: ~0 + 1 sets C and Z, then ADC picks up carry=1.
    send(ADD, '1, 64'd1, 5'd4);
    step();
    check("chain_wb_data", bus.wb_data, 64'd0);
    check("chain_flags",   64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'b110);
    send(ADC, 64'd0, 64'd0, 5'd5);
    check("chain_alu_carry", 64'(bus.alu_carry), 64'd1);
    step();
    check("chain_adc_data", bus.wb_data, 64'd1);

    // Negative extreme result.
    send(ADD, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd6);
    step();
    check("neg_wb_data", bus.wb_data, 64'h8000_0000_0000_0000);
    check("neg_flags",   64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'b001);
    step();

    // Divide by zero: trap at T+5, flags untouched, held until ack.
    send(DIV, 64'd9, 64'd0, 5'd7);
    repeat (3) step();
    check("dz_no_trap_c4", 64'(bus.trap_valid), 64'd0);
    step();
    check("dz_trap_c5",    64'(bus.trap_valid), 64'd1);
    check("dz_cause",      64'(bus.trap_cause), 64'(DIVIDE_BY_ZERO));
    check("dz_no_wb",      64'(bus.wb_valid),   64'd0);
    check("dz_flags_kept", 64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'b001);
    repeat (2) step();
    check("dz_held_trap",  64'(bus.trap_valid), 64'd1);
    check("dz_held_ready", 64'(bus.in_ready),   64'd0);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    #1;
    check("dz_ready_after_ack", 64'(bus.in_ready),   64'd1);
    check("dz_cause_kept",      64'(bus.trap_cause), 64'(DIVIDE_BY_ZERO));

    // Backpressure for 5 cycles, then writeback and new op in the same cycle.
    bus.wb_ready = 1'b0;
    send(SUB, 64'd100, 64'd58, 5'd9);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
      check("bp_wb_data",  bus.wb_data,       64'd42);
      check("bp_wb_rd",    64'(bus.wb_rd),    64'd9);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.wb_ready = 1'b1;
    send(XOR, 64'hffff, 64'h0f0f, 5'd10);
    check("ovl_exec_no_wb", 64'(bus.wb_valid), 64'd0);
    step();
    check("ovl_wb_valid",   64'(bus.wb_valid), 64'd1);
    check("ovl_wb_data",    bus.wb_data,       64'hf0f0);
    check("ovl_wb_rd",      64'(bus.wb_rd),    64'd10);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.in_op    = opcode_t'(4'($urandom_range(0, 13)));
      bus.in_a     = rand_q();
      bus.in_b     = rand_q();
      bus.in_rd    = RW'($urandom);
      bus.wb_ready = ($urandom_range(0, 9) < 7);
      bus.trap_ack = ($urandom_range(0, 9) < 3);
      step();
    end

    // Drain, then reset in the middle of a DIV.
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    bus.trap_ack = 1'b1;
    repeat (10) step();
    bus.trap_ack = 1'b0;
    send(DIV, 64'd100, 64'd7, 5'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(bus.in_ready),   64'd0);
    check("mid_rst_alu_op",   64'(bus.alu_op),     64'd0);
    check("mid_rst_alu_a",    bus.alu_a,           64'd0);
    check("mid_rst_alu_b",    bus.alu_b,           64'd0);
    check("mid_rst_carry",    64'(bus.alu_carry),  64'd0);
    check("mid_rst_flags",    64'({bus.flag_c, bus.flag_z, bus.flag_n}), 64'd0);
    check("mid_rst_wb_data",  bus.wb_data,         64'd0);
    check("mid_rst_wb_rd",    64'(bus.wb_rd),      64'd0);
    check("mid_rst_cause",    64'(bus.trap_cause), 64'(NONE));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("post_rst_no_wb",   64'(bus.wb_valid),   64'd0);
      check("post_rst_no_trap", 64'(bus.trap_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
